// File: rtl/demod_segment_bank.sv
// demod_segment_bank
//
// BPSK segment demodulator for one frame of NSEG signed fixed-point samples,
// taken one sample per accepted cycle. Each sample is sliced against zero and
// mapped onto the alternating per-segment reference (+1.0 on even segments,
// -1.0 on odd ones) or its negation.
//
// Build option:
//   DEMOD_SOFT_EN - when defined, seg_out carries the soft value
//                   sample_in * sign(ref[i]) instead of the hard +/-1.0.
//                   The most negative input saturates on negation.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous, active-high
//   start        - frame start request, honoured only while idle
//   sample_in    - signed input sample (WIDTH bits, FRAC fractional bits)
//   sample_valid - qualifies sample_in
//   seg_out      - demodulated segment value
//   seg_idx      - segment index belonging to seg_out
//   seg_valid    - one-cycle qualifier for seg_out/seg_idx
//   bits_out     - hard decisions of the last completed frame (bit i = segment i)
//   ambig_cnt    - zero-valued samples seen in the last completed frame
//   valid        - one-cycle frame-complete pulse
//   busy         - high while a frame is being collected

module demod_segment_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned NSEG  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          sample_in,
    input  logic                      sample_valid,
    output logic [WIDTH-1:0]          seg_out,
    output logic [$clog2(NSEG)-1:0]   seg_idx,
    output logic                      seg_valid,
    output logic [NSEG-1:0]           bits_out,
    output logic [$clog2(NSEG+1)-1:0] ambig_cnt,
    output logic                      valid,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NSEG);
    localparam int unsigned AW = $clog2(NSEG + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] NEG_ONE  = ~POS_ONE + WIDTH'(1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NSEG - 1);

    logic [0:0]      state_q;
    logic [IW-1:0]   idx_q;
    logic [NSEG-1:0] bits_work_q;
    logic [AW-1:0]   ambig_work_q;
    logic [WIDTH-1:0] seg_q;
    logic [IW-1:0]   seg_idx_q;
    logic            seg_valid_q;
    logic [NSEG-1:0] bits_out_q;
    logic [AW-1:0]   ambig_out_q;
    logic            valid_q;

    logic            pos;
    logic            zero;
    logic [WIDTH-1:0] seg_d;
    logic [NSEG-1:0] bits_d;
    logic [AW-1:0]   ambig_d;

    always_comb begin
        // Strictly positive: sign bit clear and not zero.
        zero = (sample_in == '0);
        pos  = ~sample_in[WIDTH-1] & ~zero;

`ifdef DEMOD_SOFT_EN
        if (!idx_q[0]) begin
            seg_d = sample_in;
        end else if (sample_in == {1'b1, {(WIDTH-1){1'b0}}}) begin
            seg_d = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            seg_d = ~sample_in + WIDTH'(1);
        end
`else
        // Positive on even or non-positive on odd both land on +1.0.
        seg_d = (pos ^ idx_q[0]) ? POS_ONE : NEG_ONE;
`endif

        bits_d         = bits_work_q;
        bits_d[idx_q]  = pos;
        ambig_d        = ambig_work_q + AW'(zero);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            bits_work_q  <= '0;
            ambig_work_q <= '0;
            seg_q        <= '0;
            seg_idx_q    <= '0;
            seg_valid_q  <= 1'b0;
            bits_out_q   <= '0;
            ambig_out_q  <= '0;
            valid_q      <= 1'b0;
        end else begin
            seg_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_COLLECT;
                        idx_q        <= '0;
                        bits_work_q  <= '0;
                        ambig_work_q <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (sample_valid) begin
                        seg_q        <= seg_d;
                        seg_idx_q    <= idx_q;
                        seg_valid_q  <= 1'b1;
                        bits_work_q  <= bits_d;
                        ambig_work_q <= ambig_d;
                        if (idx_q == LAST_IDX) begin
                            // Shadow outputs only move on frame completion.
                            state_q     <= ST_IDLE;
                            idx_q       <= '0;
                            valid_q     <= 1'b1;
                            bits_out_q  <= bits_d;
                            ambig_out_q <= ambig_d;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign seg_out   = seg_q;
    assign seg_idx   = seg_idx_q;
    assign seg_valid = seg_valid_q;
    assign bits_out  = bits_out_q;
    assign ambig_cnt = ambig_out_q;
    assign valid     = valid_q;
    assign busy      = (state_q == ST_COLLECT);

endmodule
